// File: rtl/cic_sample_scheduler_pkg.sv
// Shared definitions for the CIC sample scheduler: FSM state encoding and
// the channel-id tag width derivation.
package cic_sample_scheduler_pkg;

  // Two-state issue FSM: IDLE looks for a pending channel, ISSUE waits for
  // the serializer to accept the word currently on ser_word.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } sched_state_t;

  // Channel-id tag width: ceil(log2(n)), never below one bit.
  function automatic int ch_w_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cic_sample_scheduler_rr_arbiter.sv
// Combinational rotate-priority encoder. Grants the first requesting channel
// at or after ptr, wrapping modulo NUM_CH.
module cic_sample_scheduler_rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic              gnt_valid,
  output logic [CH_W-1:0]   gnt_id
);

  logic [2*NUM_CH-1:0] req_dbl;
  logic [2*NUM_CH-1:0] req_rot;
  logic [CH_W:0]       offset;
  logic [CH_W:0]       sum;

  // Rotate requests so bit k is channel (ptr+k) mod NUM_CH, then pick the
  // lowest set bit and translate the offset back into a channel id.
  always_comb begin
    req_dbl   = {req, req};
    req_rot   = req_dbl >> ptr;
    gnt_valid = 1'b0;
    offset    = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        gnt_valid = 1'b1;
        offset    = (CH_W+1)'(k);
      end
    end
    sum = {1'b0, ptr} + offset;
    if (sum >= (CH_W+1)'(NUM_CH)) begin
      sum = sum - (CH_W+1)'(NUM_CH);
    end
    gnt_id = sum[CH_W-1:0];
  end

endmodule

// File: rtl/cic_sample_scheduler.sv
// Shares one serializer between NUM_CH CIC channels. Each channel's strobed
// sample lands in a one-deep holding register; a round-robin FSM issues held
// samples as {ch_id, sample} over a valid/ready link and counts overruns.
//
// Handshake: a word transfers on a clock edge where ser_valid and ser_ready
// are both 1. While ser_valid is 1, ser_word is held stable and ser_valid
// only drops after such a transfer (or reset); ser_ready with ser_valid=0
// has no effect.
module cic_sample_scheduler
  import cic_sample_scheduler_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 13,
  parameter int CH_W   = ch_w_of(NUM_CH),
  parameter int OVR_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_strobe,
  output logic [CH_W+DATA_W-1:0]   ser_word,
  output logic                     ser_valid,
  input  logic                     ser_ready,
  output logic [NUM_CH-1:0]        ovr_flag,
  output logic [NUM_CH*OVR_W-1:0]  ovr_count,
  input  logic                     ovr_clear,
  output logic                     dbg_state
);

  localparam logic [OVR_W-1:0] OVR_MAX = '1;

  sched_state_t      state;
  logic [CH_W-1:0]   rr_ptr;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] pend_nxt;
  logic [NUM_CH-1:0] take;
  logic [NUM_CH-1:0] overrun;
  logic [DATA_W-1:0] hold [NUM_CH];
  logic [OVR_W-1:0]  cnt  [NUM_CH];

  logic              gnt_valid;
  logic [CH_W-1:0]   gnt_id;
  logic              grant_fire;
  logic [CH_W-1:0]   cur_id;
  logic [CH_W-1:0]   rr_next;

  cic_sample_scheduler_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req       (pend),
    .ptr       (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign grant_fire = (state == ST_IDLE) && enable && gnt_valid;
  assign cur_id     = ser_word[DATA_W +: CH_W];
  assign rr_next    = (cur_id == CH_W'(NUM_CH - 1)) ? '0 : cur_id + CH_W'(1);
  assign dbg_state  = state;

  // Per-channel pending/overrun decode. A channel's pending bit is released
  // the moment its sample is copied into ser_word, so a strobe arriving while
  // that word waits for the serializer is a fresh sample, not an overrun.
  always_comb begin
    take     = '0;
    overrun  = '0;
    pend_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      take[i]     = grant_fire && (gnt_id == CH_W'(i));
      overrun[i]  = enable && ch_strobe[i] && pend[i] && !take[i];
      pend_nxt[i] = enable && (ch_strobe[i] || (pend[i] && !take[i]));
    end
  end

  // Capture strobed samples; the newest sample on a channel always wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      for (int i = 0; i < NUM_CH; i++) hold[i] <= '0;
    end else begin
      pend <= pend_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        if (enable && ch_strobe[i]) hold[i] <= ch_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Sticky overrun flags and saturating counts; an overrun beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_flag <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (overrun[i]) begin
          ovr_flag[i] <= 1'b1;
          if (ovr_clear)             cnt[i] <= OVR_W'(1);
          else if (cnt[i] != OVR_MAX) cnt[i] <= cnt[i] + OVR_W'(1);
        end else if (ovr_clear) begin
          ovr_flag[i] <= 1'b0;
          cnt[i]      <= '0;
        end
      end
    end
  end

  // Flatten the per-channel counters onto the output bus, ch0 in the LSBs.
  always_comb begin
    ovr_count = '0;
    for (int i = 0; i < NUM_CH; i++) ovr_count[i*OVR_W +: OVR_W] = cnt[i];
  end

  // Issue FSM: grant a pending channel, then hold the word until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ser_valid <= 1'b0;
      ser_word  <= '0;
      rr_ptr    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_fire) begin
            ser_word  <= {gnt_id, hold[gnt_id]};
            ser_valid <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (ser_ready) begin
            ser_valid <= 1'b0;
            rr_ptr    <= rr_next;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          ser_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cic_sample_scheduler.sv
// Bench for cic_sample_scheduler: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a behavioural model and a word
// scoreboard.
module tb_cic_sample_scheduler;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 13;
  localparam int OVR_W  = 8;
  localparam int CH_W   = 1;
  localparam int W      = CH_W + DATA_W;
  localparam int OVR_SAT = 255;

  // ---------------- clock / reset / DUT ----------------
  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     enable = 1'b0;
  logic [NUM_CH*DATA_W-1:0] ch_data = '0;
  logic [NUM_CH-1:0]        ch_strobe = '0;
  logic [W-1:0]             ser_word;
  logic                     ser_valid;
  logic                     ser_ready = 1'b0;
  logic [NUM_CH-1:0]        ovr_flag;
  logic [NUM_CH*OVR_W-1:0]  ovr_count;
  logic                     ovr_clear = 1'b0;
  logic                     dbg_state;

  always #5 clk = ~clk;

  cic_sample_scheduler #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .CH_W   (CH_W),
    .OVR_W  (OVR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .ch_data   (ch_data),
    .ch_strobe (ch_strobe),
    .ser_word  (ser_word),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .ovr_flag  (ovr_flag),
    .ovr_count (ovr_count),
    .ovr_clear (ovr_clear),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit                m_pend [NUM_CH];
  logic [DATA_W-1:0] m_hold [NUM_CH];
  int                m_cnt  [NUM_CH];
  bit                m_flag [NUM_CH];
  bit                m_busy;
  int                m_id;
  logic [DATA_W-1:0] m_data;
  int                m_rr;

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    int gnt;
    logic [DATA_W-1:0] gd;
    logic [CH_W-1:0] idv;
    bit st, ov, taken;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_pend[i] = 0; m_hold[i] = '0; m_cnt[i] = 0; m_flag[i] = 0;
      end
      m_busy = 0; m_id = 0; m_data = '0; m_rr = 0;
      return;
    end
    gnt = -1;
    gd  = '0;
    if (!m_busy && enable) begin
      for (int k = 0; k < NUM_CH; k++) begin
        int c;
        c = (m_rr + k) % NUM_CH;
        if (gnt < 0 && m_pend[c]) gnt = c;
      end
    end
    if (m_busy && ser_ready) begin
      idv = m_id[CH_W-1:0];
      exp_q.push_back({idv, m_data});
      m_busy = 0;
      m_rr = (m_id + 1) % NUM_CH;
    end
    if (gnt >= 0) gd = m_hold[gnt];
    for (int i = 0; i < NUM_CH; i++) begin
      taken = (gnt == i);
      st    = ch_strobe[i];
      ov    = enable && st && m_pend[i] && !taken;
      m_pend[i] = enable && (st || (m_pend[i] && !taken));
      if (enable && st) m_hold[i] = ch_data[i*DATA_W +: DATA_W];
      if (ov) begin
        m_flag[i] = 1;
        if (ovr_clear)            m_cnt[i] = 1;
        else if (m_cnt[i] < OVR_SAT) m_cnt[i] = m_cnt[i] + 1;
      end else if (ovr_clear) begin
        m_flag[i] = 0;
        m_cnt[i]  = 0;
      end
    end
    if (gnt >= 0) begin
      m_busy = 1;
      m_id   = gnt;
      m_data = gd;
    end
  endtask

  task automatic compare_outputs();
    logic [W-1:0] ew;
    logic [CH_W-1:0] idv;
    logic [NUM_CH-1:0] ef;
    logic [NUM_CH*OVR_W-1:0] ec;
    idv = m_id[CH_W-1:0];
    ew  = {idv, m_data};
    for (int i = 0; i < NUM_CH; i++) begin
      ef[i] = m_flag[i];
      ec[i*OVR_W +: OVR_W] = m_cnt[i][OVR_W-1:0];
    end
    check("cyc_valid", ser_valid, m_busy);
    check("cyc_word", ser_word, ew);
    check("cyc_flag", ovr_flag, ef);
    check("cyc_count", ovr_count, ec);
    check("cyc_state", dbg_state, m_busy);
  endtask

  // ---------------- driver tasks ----------------
  // One clock: update the model, retire any DUT handshake against the
  // scoreboard, then compare all outputs just after the edge.
  task automatic cycle();
    logic [W-1:0] w;
    model_step();
    if (!rst && ser_valid && ser_ready) begin
      check("sb_avail", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check("sb_word", ser_word, w);
      end
    end
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1; ch_strobe = '0; ovr_clear = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic strobe_ch(input int ch, input logic [DATA_W-1:0] d);
    ch_strobe = '0;
    ch_strobe[ch] = 1'b1;
    ch_data[ch*DATA_W +: DATA_W] = d;
    cycle();
    ch_strobe = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset state
    do_reset();
    check("rst_valid", ser_valid, 0);
    check("rst_word", ser_word, 0);
    check("rst_flag", ovr_flag, 0);
    check("rst_count", ovr_count, 0);

    // single ch0 sample of -5, serializer ready
    enable = 1'b1; ser_ready = 1'b1;
    strobe_ch(0, 13'h1FFB);
    check("t1_lat1", ser_valid, 0);
    cycle();
    check("t1_valid", ser_valid, 1);
    check("t1_word", ser_word, 14'h1FFB);
    cycle();
    check("t1_one_beat", ser_valid, 0);
    check("t1_noovr", ovr_flag, 0);

    // simultaneous pair, round robin then wrap back to ch0
    do_reset();
    enable = 1'b1; ser_ready = 1'b1;
    ch_strobe = 2'b11;
    ch_data = {13'd200, 13'd100};
    cycle();
    ch_strobe = '0;
    cycle();
    check("t2_first", ser_word, {1'b0, 13'd100});
    cycle();
    cycle();
    check("t2_second", ser_word, {1'b1, 13'd200});
    ch_strobe = 2'b11;
    ch_data = {13'd8, 13'd7};
    cycle();
    ch_strobe = '0;
    cycle();
    check("t2_wrap", ser_word, {1'b0, 13'd7});
    idle(4);

    // back-pressure: word frozen, newest pending sample wins, one overrun
    do_reset();
    enable = 1'b1; ser_ready = 1'b0;
    strobe_ch(1, 13'd1);
    cycle();
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      strobe_ch(1, 13'd2);
      else if (i == 3) strobe_ch(1, 13'd3);
      else             cycle();
      check("t3_hold_valid", ser_valid, 1);
      check("t3_hold_word", ser_word, {1'b1, 13'd1});
    end
    ser_ready = 1'b1;
    cycle();
    check("t3_drop", ser_valid, 0);
    cycle();
    check("t3_second", ser_word, {1'b1, 13'd3});
    check("t3_cnt1", ovr_count[OVR_W +: OVR_W], 1);
    check("t3_flag1", ovr_flag[1], 1);
    idle(3);

    // counter saturation, clear, clear colliding with overrun
    do_reset();
    enable = 1'b1; ser_ready = 1'b0;
    ch_strobe = 2'b01;
    for (int i = 0; i < 301; i++) begin
      ch_data[0 +: DATA_W] = DATA_W'($urandom);
      cycle();
    end
    ch_strobe = '0;
    check("t4_sat", ovr_count[0 +: OVR_W], 255);
    check("t4_flag", ovr_flag[0], 1);
    ovr_clear = 1'b1;
    cycle();
    ovr_clear = 1'b0;
    check("t4_clr_cnt", ovr_count[0 +: OVR_W], 0);
    check("t4_clr_flag", ovr_flag[0], 0);
    ovr_clear = 1'b1;
    strobe_ch(0, 13'd55);
    ovr_clear = 1'b0;
    check("t4_clr_ovr_cnt", ovr_count[0 +: OVR_W], 1);
    check("t4_clr_ovr_flag", ovr_flag[0], 1);
    ser_ready = 1'b1;
    idle(4);

    // enable drop while issuing: in-flight word completes, pending dropped
    do_reset();
    enable = 1'b1; ser_ready = 1'b0;
    strobe_ch(0, 13'd11);
    cycle();
    strobe_ch(1, 13'd22);
    enable = 1'b0;
    cycle();
    check("t5_inflight", ser_valid, 1);
    ser_ready = 1'b1;
    cycle();
    for (int i = 0; i < 5; i++) begin
      check("t5_quiet", ser_valid, 0);
      cycle();
    end
    enable = 1'b1;

    // reset mid-transfer, then normal issue
    do_reset();
    enable = 1'b1; ser_ready = 1'b0;
    strobe_ch(0, 13'd5);
    cycle();
    strobe_ch(0, 13'd6);
    strobe_ch(0, 13'd7);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t6_valid", ser_valid, 0);
    check("t6_word", ser_word, 0);
    check("t6_count", ovr_count, 0);
    check("t6_flag", ovr_flag, 0);
    cycle();
    cycle();
    ser_ready = 1'b1;
    strobe_ch(1, 13'd9);
    cycle();
    check("t6_reissue", ser_word, {1'b1, 13'd9});
    check("t6_revalid", ser_valid, 1);
    idle(2);

    // randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 599) == 0);
      enable    = ($urandom_range(0, 19) != 0);
      ser_ready = ($urandom_range(0, 3) != 0);
      ovr_clear = ($urandom_range(0, 79) == 0);
      for (int i = 0; i < NUM_CH; i++) begin
        ch_strobe[i] = ($urandom_range(0, 3) == 0);
        ch_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
      end
      cycle();
    end
    rst = 1'b0; ch_strobe = '0; ovr_clear = 1'b0; ser_ready = 1'b1;
    idle(6);
    check("sb_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
